seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Four-digit multiplexed seven-segment display driver that sits directly downstream of the clock divider, consuming its `clk_7seg_scan[1:0]` digit-select and `clk_blink` outputs. It holds a CPU-written 16-bit hex value in a shadow register and commits it only at the start of a scan frame, so the display never tears. It inserts anode dead-time on every digit change to suppress ghosting, and drives registered active-low anode/segment/decimal-point pins.

## Interface
- `BLANK_CYCLES`, 4: anode-off dead-time in `clk_in` cycles after each digit change; legal range 1–255.
- `clk_in` input 1: system clock; the same clock that feeds the divider, so `scan_sel` and `blink` are synchronous.
- `rst` input 1: reset, asynchronous, active-high.
- `scan_sel` input 2: digit select, driven by the divider's `clk_7seg_scan`.
- `blink` input 1: blink phase, driven by the divider's `clk_blink`.
- `wr_en` input 1: one-cycle write strobe from the CPU/IO side.
- `wr_data` input 16: four hex nibbles; digit k uses bits [4k+3:4k].
- `dp_in` input 4: decimal point per digit, 1 = lit; captured with `wr_data`.
- `blink_mask` input 4: per-digit blink enable; used live, not latched.
- `an` output 4: anodes, active-low.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point, active-low.
- `pending` output 1: 1 while a written value is waiting for a commit.

## Operation
- **Registers:**
  - `shadow[19:0]` holds {dp, data}.
  - `active[19:0]` holds the displayed value.
  - `pending` flag.
  - `scan_q[1:0]` holds the previous `scan_sel`.
  - `cnt[7:0]` counts dead-time.
  - `state` is one of BLANK or DRIVE.
- **Change detect:** `chg = (scan_sel != scan_q)`. `scan_q <= scan_sel` every cycle.
- **Write:** `wr_en` loads `shadow <= {dp_in, wr_data}` and sets `pending`. Back-to-back writes overwrite; the last one wins.
- **Commit:**
  - Occurs when `chg && scan_sel==2'd0 && pending`.
  - Action: `active <= shadow`, clear `pending`.
  - If `wr_en` occurs in the same cycle, the commit takes the old shadow. The new data loads into shadow and `pending` stays 1.
- **State machine:**
  - BLANK: `an=4'b1111`, `seg=7'h7F`, `dp=1`. `cnt` increments each cycle. After `cnt==BLANK_CYCLES-1`, go to DRIVE.
  - DRIVE:
    - Digit `d=scan_q`.
    - `an[d]=0`, all other anodes 1.
    - `seg=decode(active[4d+3:4d])`.
    - `dp=~active[16+d]`.
  - From any state, `chg` goes to BLANK with `cnt<=0`. A change during BLANK restarts the count.
- **Blink:** in DRIVE, if `blink_mask[d] && blink`, then `an=4'b1111` and `dp=1`.
- **Decode (active-low {g..a}):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Reset (async):**
  - Outputs: `an=4'b1111`, `seg=7'h7F`, `dp=1`, `pending=0`.
  - Internal: `shadow=0`, `active=0`, `scan_q=0`, `cnt=0`, state=BLANK.
  - Assertion mid-frame or mid-dead-time forces all outputs off immediately.
  - After release, the block stays in BLANK for `BLANK_CYCLES` cycles, then drives digit `scan_q`.

## Timing
- All outputs are registered.
- `scan_sel` change at cycle N:
  - `an` goes all-off at N+1.
  - The new digit is lit at N+1+BLANK_CYCLES.
- Commit at cycle N: new value appears on `seg` at the first DRIVE cycle of digit 0, i.e. N+1+BLANK_CYCLES. `pending` falls at N+1.
- `wr_en` at cycle N: `pending` is 1 at N+1.
- `blink`/`blink_mask` change at N: reflected on `an` at N+1.
- Steady-state duty per digit is (scan period − BLANK_CYCLES) / scan period.

## Configuration
- `SEG7_LZB_EN` (leading-zero blanking):
  - **Defined:** in DRIVE, digit d∈{3,2,1} shows `an=4'b1111` and `dp=1` if nibble d and all higher nibbles of `active` are 0. The lit-dp check applies only when the dp bit is also 0; a lit dp on a digit disables blanking of that digit and all lower digits. Digit 0 is never blanked.
  - **Undefined:** all four digits are always driven; 0x0042 displays as "0042".

## Test plan
- **Reset:** assert `rst` mid-DRIVE → `an=1111`, `seg=7F`, `dp=1`, `pending=0` within the same cycle, without a clock edge.
- **Commit:**
  - Write 0x12AF with dp_in=0001 while `scan_sel=2` → `pending=1` and the display is unchanged.
  - At the 3→0 transition, `pending` falls.
  - Digit 0 shows F (0001110, dp=0), digit 1 A (0001000), digit 2 2, digit 3 1.
- **Dead-time:** BLANK_CYCLES=4, change `scan_sel` 0→1 at N → `an=1111` for cycles N+1..N+4, then `an=1101` at N+5. Changing again at N+2 restarts the count.
- **Simultaneous:** `wr_en` (0xBEEF) in the same cycle as the commit of 0x1234 → display 0x1234 and `pending` stays 1. 0xBEEF commits at the next wrap.
- **Blink:** blink_mask=0100 with `blink` toggling → digit 2 anode off whenever `blink=1`; the other digits are unaffected.
- **LZB** (with `SEG7_LZB_EN`): 0x0042 → digits 3,2 dark and "42" shown. 0x0000 → only digit 0 lit, showing 0. Without the macro, 0x0042 shows "0042".

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: four-digit multiplexed seven-segment driver.
// CPU writes land in a shadow register and are committed at the start of a
// scan frame (entry to digit 0) so the display never tears. Every digit change
// inserts BLANK_CYCLES of anode dead-time. All pins are registered, active-low.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking of digits 3..1.
module seg7_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [1:0]  scan_sel,
  input  logic        blink,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending
);

  localparam logic [0:0] BLANK    = 1'b0;
  localparam logic [0:0] DRIVE    = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);

  logic [19:0] shadow_q, shadow_d;
  logic [19:0] active_q, active_d;
  logic        pending_q, pending_d;
  logic [1:0]  scan_q, scan_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [0:0]  state_q, state_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic            chg;
  logic            commit;
  logic [3:0][3:0] nibs;
  logic [3:0]      dps;
`ifdef SEG7_LZB_EN
  logic [3:0]      lz;
`endif

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h7F;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next-state: write/commit, dead-time FSM, and the pin values for the next cycle.
  // Pins are computed from the next state so they line up with the registered FSM.
  always_comb begin
    chg       = (scan_sel != scan_q);
    commit    = chg && (scan_sel == 2'd0) && pending_q;

    // Commit takes the old shadow even when a write lands in the same cycle.
    active_d  = commit ? shadow_q : active_q;
    shadow_d  = wr_en ? {dp_in, wr_data} : shadow_q;
    pending_d = wr_en ? 1'b1 : (commit ? 1'b0 : pending_q);
    scan_d    = scan_sel;

    state_d   = state_q;
    cnt_d     = cnt_q;
    if (chg) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else if (state_q == BLANK) begin
      if (cnt_q == CNT_LAST) begin
        state_d = DRIVE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    nibs = active_d[15:0];
    dps  = active_d[19:16];
`ifdef SEG7_LZB_EN
    lz[3] = (nibs[3] == 4'h0) && !dps[3];
    lz[2] = lz[3] && (nibs[2] == 4'h0) && !dps[2];
    lz[1] = lz[2] && (nibs[1] == 4'h0) && !dps[1];
    lz[0] = 1'b0;
`endif

    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_d == DRIVE) begin
      seg_d = decode(nibs[scan_d]);
      dp_d  = ~dps[scan_d];
      an_d  = ~(4'b0001 << scan_d);
      if (blink_mask[scan_d] && blink) begin
        an_d = '1;
        dp_d = 1'b1;
      end
`ifdef SEG7_LZB_EN
      if (lz[scan_d]) begin
        an_d = '1;
        dp_d = 1'b1;
      end
`endif
    end
  end

  // State and output registers with asynchronous reset to all-off.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      scan_q    <= '0;
      cnt_q     <= '0;
      state_q   <= BLANK;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      scan_q    <= scan_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a timeline model (cycles since last digit change,
// frame-start commit) checked against the pins every cycle, plus literal pins.
module tb_seg7_scan_driver;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  scan_sel = 2'd0;
  logic        blink = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_driver #(.BLANK_CYCLES(BC)) dut (
    .clk_in(clk), .rst(rst), .scan_sel(scan_sel), .blink(blink),
    .wr_en(wr_en), .wr_data(wr_data), .dp_in(dp_in), .blink_mask(blink_mask),
    .an(an), .seg(seg), .dp(dp), .pending(pending)
  );

  always #5 clk = ~clk;

  logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: age = clock edges since the last digit change (or reset).
  int         m_age;
  logic [1:0] m_prev;
  logic [19:0] m_shadow, m_active;
  logic       m_pending, m_blink;
  logic [3:0] m_mask;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_prev = 2'd0; m_shadow = '0; m_active = '0;
      m_pending = 1'b0; m_blink = 1'b0; m_mask = '0;
    end else begin
      if (scan_sel != m_prev && scan_sel == 2'd0 && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (wr_en) begin
        m_shadow  = {dp_in, wr_data};
        m_pending = 1'b1;
      end
      if (scan_sel != m_prev) m_age = 0;
      else if (m_age < 1000) m_age = m_age + 1;
      m_prev  = scan_sel;
      m_blink = blink;
      m_mask  = blink_mask;
    end
  end

  // Is digit d dark because it and all higher digits are zero with no lit dp?
  function automatic bit lzb_dark(input logic [19:0] v, input int d);
    bit dark;
    dark = 1'b0;
`ifdef SEG7_LZB_EN
    if (d != 0) begin
      dark = 1'b1;
      for (int k = d; k < 4; k++)
        if (((v >> (4 * k)) & 20'hF) != 0 || v[16 + k]) dark = 1'b0;
    end
`endif
    return dark;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d;
    d = int'(m_prev);
    if (m_age < BC) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_seg = SEG_TAB[(m_active >> (4 * d)) & 20'hF];
      e_dp  = ~m_active[16 + d];
      e_an  = ~(4'b0001 << d);
      if ((m_blink && m_mask[d]) || lzb_dark(m_active, d)) begin
        e_an = 4'hF; e_dp = 1'b1;
      end
    end
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_pending", 32'(pending), 32'(m_pending));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto_digit(input logic [1:0] s);
    scan_sel = s;
    step(BC + 2);
  endtask

  task automatic write(input logic [15:0] v, input logic [3:0] p);
    wr_en = 1'b1; wr_data = v; dp_in = p;
    step(1);
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    step(3);
    chk("post_rst_still_blank", 32'(an), 32'hF);
    step(1);
    chk("post_rst_lit_an", 32'(an), 32'b1110);
    chk("post_rst_lit_seg", 32'(seg), 32'b1000000);

    // Commit of 0x12AF, dp on digit 0
    goto_digit(2'd1);
    goto_digit(2'd2);
    write(16'h12AF, 4'b0001);
    chk("wr_pending", 32'(pending), 32'h1);
    step(3);
    goto_digit(2'd3);
    scan_sel = 2'd0;
    step(1);
    chk("commit_pending_falls", 32'(pending), 32'h0);
    step(BC - 1);
    chk("commit_still_blank", 32'(an), 32'hF);
    step(1);
    chk("d0_an", 32'(an), 32'b1110);
    chk("d0_seg_F", 32'(seg), 32'b0001110);
    chk("d0_dp_lit", 32'(dp), 32'h0);
    goto_digit(2'd1);
    chk("d1_an", 32'(an), 32'b1101);
    chk("d1_seg_A", 32'(seg), 32'b0001000);
    chk("d1_dp_off", 32'(dp), 32'h1);
    goto_digit(2'd2);
    chk("d2_seg_2", 32'(seg), 32'b0100100);
    goto_digit(2'd3);
    chk("d3_seg_1", 32'(seg), 32'b1111001);

    // Dead-time and restart
    goto_digit(2'd0);
    scan_sel = 2'd1;
    for (int i = 0; i < BC; i++) begin
      step(1);
      chk("dead_an_off", 32'(an), 32'hF);
    end
    step(1);
    chk("dead_then_d1", 32'(an), 32'b1101);
    scan_sel = 2'd2;
    step(2);
    scan_sel = 2'd3;
    step(BC);
    chk("restart_still_off", 32'(an), 32'hF);
    step(1);
    chk("restart_d3_lit", 32'(an), 32'b0111);

    // Write coinciding with commit
    goto_digit(2'd2);
    write(16'h1234, 4'b0000);
    goto_digit(2'd3);
    scan_sel = 2'd0; wr_en = 1'b1; wr_data = 16'hBEEF; dp_in = 4'b0000;
    step(1);
    wr_en = 1'b0;
    chk("simul_pending_stays", 32'(pending), 32'h1);
    step(BC);
    chk("simul_d0_seg_4", 32'(seg), 32'b0011001);
    goto_digit(2'd1);
    chk("simul_d1_seg_3", 32'(seg), 32'b0110000);
    goto_digit(2'd2);
    goto_digit(2'd3);
    goto_digit(2'd0);
    chk("beef_d0_seg_F", 32'(seg), 32'b0001110);
    chk("beef_pending_clear", 32'(pending), 32'h0);
    goto_digit(2'd1);
    chk("beef_d1_seg_E", 32'(seg), 32'b0000110);

    // Blink on digit 2 only
    goto_digit(2'd2);
    blink_mask = 4'b0100;
    blink = 1'b1;
    step(1);
    chk("blink_d2_off", 32'(an), 32'hF);
    blink = 1'b0;
    step(1);
    chk("blink_d2_on", 32'(an), 32'b1011);
    for (int i = 0; i < 6; i++) begin
      blink = ~blink;
      step(1);
    end
    blink = 1'b1;
    goto_digit(2'd1);
    chk("blink_d1_unaffected", 32'(an), 32'b1101);
    blink = 1'b0;
    blink_mask = '0;

    // Leading zeros: 0x0042
    write(16'h0042, 4'b0000);
    goto_digit(2'd2);
    goto_digit(2'd3);
    goto_digit(2'd0);
    chk("lz_d0_seg_2", 32'(seg), 32'b0100100);
    goto_digit(2'd1);
    chk("lz_d1_seg_4", 32'(seg), 32'b0011001);
    chk("lz_d1_an", 32'(an), 32'b1101);
    goto_digit(2'd2);
`ifdef SEG7_LZB_EN
    chk("lz_d2_dark", 32'(an), 32'hF);
`else
    chk("lz_d2_lit", 32'(an), 32'b1011);
    chk("lz_d2_seg_0", 32'(seg), 32'b1000000);
`endif
    goto_digit(2'd3);
    // 0x0000, then 0x0042 with dp on digit 2
    write(16'h0000, 4'b0000);
    goto_digit(2'd0);
    chk("zero_d0_lit", 32'(an), 32'b1110);
    goto_digit(2'd1);
`ifdef SEG7_LZB_EN
    chk("zero_d1_dark", 32'(an), 32'hF);
`else
    chk("zero_d1_lit", 32'(an), 32'b1101);
`endif
    write(16'h0042, 4'b0100);
    goto_digit(2'd2);
    goto_digit(2'd3);
    goto_digit(2'd0);
    goto_digit(2'd2);
    chk("dp_d2_lit", 32'(an), 32'b1011);
    goto_digit(2'd3);

    // Asynchronous reset mid-drive
    goto_digit(2'd1);
    write(16'h5555, 4'b1111);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_dp", 32'(dp), 32'h1);
    chk("async_pending", 32'(pending), 32'h0);
    step(2);
    rst = 1'b0;
    step(BC + 3);
    chk("after_async_d1", 32'(an), 32'b1101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
